// File: rtl/aes_round_pipe_if.sv
`default_nettype none
// ============================================================================
// Module   : aes_round_pipe_if
// Brief    : Beat-in / beat-out valid-ready bundle for the AES round engine.
// Revision : 1.0 - initial release
// ============================================================================
interface aes_round_pipe_if #(
    parameter int TAG_W = 4
);
    logic             in_valid;
    logic             in_ready;
    logic [127:0]     state_in;
    logic [127:0]     round_key;
    logic             final_round;
    logic             decrypt;
    logic [TAG_W-1:0] in_tag;

    logic             out_valid;
    logic             out_ready;
    logic [127:0]     state_out;
    logic [TAG_W-1:0] out_tag;

    modport master (
        output in_valid, state_in, round_key, final_round, decrypt, in_tag, out_ready,
        input  in_ready, out_valid, state_out, out_tag
    );

    modport slave (
        input  in_valid, state_in, round_key, final_round, decrypt, in_tag, out_ready,
        output in_ready, out_valid, state_out, out_tag
    );
endinterface
`default_nettype wire

// File: rtl/aes_round_pipe.sv
`default_nettype none
// ============================================================================
// Module   : aes_round_pipe
// Brief    : Elastic, bidirectional AES-128 round engine with 1..3 stages.
// Revision : 1.0 - initial release
// ============================================================================
module aes_round_pipe #(
    parameter int PIPE_STAGES = 2,
    parameter int TAG_W       = 4
) (
    input  wire logic       clk,
    input  wire logic       rst,
    aes_round_pipe_if.slave bus,
    output logic            busy
);
    localparam int         c_last    = PIPE_STAGES - 1;
    localparam logic [7:0] c_inv_exp = 8'hFE;

    typedef struct packed {
        logic [127:0]     state;
        logic [127:0]     key;
        logic             fin;
        logic             dec;
        logic [TAG_W-1:0] tag;
    } beat_t;

    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = xtime(x);
        end
        return p;
    endfunction

    // Multiplicative inverse as x^254 (maps 0 to 0 as the S-box requires).
    function automatic logic [7:0] gf_inv(input logic [7:0] x);
        logic [7:0] y;
        y = 8'h01;
        for (int i = 7; i >= 0; i--) begin
            y = gf_mul(y, y);
            if (c_inv_exp[i]) y = gf_mul(y, x);
        end
        return y;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] x, input int n);
        return (x << n) | (x >> (8 - n));
    endfunction

    function automatic logic [7:0] sbox(input logic [7:0] x);
        logic [7:0] b;
        b = gf_inv(x);
        return b ^ rotl8(b, 1) ^ rotl8(b, 2) ^ rotl8(b, 3) ^ rotl8(b, 4) ^ 8'h63;
    endfunction

    function automatic logic [7:0] inv_sbox(input logic [7:0] y);
        return gf_inv(rotl8(y, 1) ^ rotl8(y, 3) ^ rotl8(y, 6) ^ 8'h05);
    endfunction

    function automatic logic [127:0] sub_bytes(input logic [127:0] s, input logic inv);
        logic [127:0] o;
        o = '0;
        for (int k = 0; k < 16; k++)
            o[127-8*k -: 8] = inv ? inv_sbox(s[127-8*k -: 8]) : sbox(s[127-8*k -: 8]);
        return o;
    endfunction

    // Byte k of the state sits in row k%4, column k/4.
    function automatic logic [127:0] shift_rows(input logic [127:0] s, input logic inv);
        logic [127:0] o;
        o = '0;
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                o[127-8*(r+4*c) -: 8] =
                    s[127-8*(r+4*(inv ? ((c-r+4)%4) : ((c+r)%4))) -: 8];
        return o;
    endfunction

    // Both matrices are circulant: row r uses coefficient (j-r) mod 4 for a_j.
    function automatic logic [127:0] mix_columns(input logic [127:0] s, input logic inv);
        logic [127:0] o;
        logic [31:0]  coef;
        logic [7:0]   acc;
        o    = '0;
        coef = inv ? 32'h0e0b0d09 : 32'h02030101;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                acc = 8'h00;
                for (int j = 0; j < 4; j++)
                    acc = acc ^ gf_mul(s[127-8*(j+4*c) -: 8], coef[31-8*((j-r+4)%4) -: 8]);
                o[127-8*(r+4*c) -: 8] = acc;
            end
        end
        return o;
    endfunction

    function automatic beat_t stage_subshift(input beat_t b);
        beat_t o;
        o       = b;
        o.state = sub_bytes(shift_rows(b.state, b.dec), b.dec);
        return o;
    endfunction

    function automatic beat_t stage_mix(input beat_t b);
        beat_t o;
        o = b;
        if (b.dec)
            o.state = b.state ^ b.key;
        else if (!b.fin)
            o.state = mix_columns(b.state, 1'b0);
        return o;
    endfunction

    function automatic logic [127:0] stage_finish(input beat_t b);
        if (b.dec)
            return b.fin ? b.state : mix_columns(b.state, 1'b1);
        return b.state ^ b.key;
    endfunction

    beat_t                  w_in_beat;
    logic [PIPE_STAGES-1:0] r_vld;
    logic [PIPE_STAGES-1:0] w_up_vld;
    logic [PIPE_STAGES-1:0] w_rdy;
    logic [127:0]           w_out_state;
    logic [TAG_W-1:0]       w_out_tag;
    logic [127:0]           r_out_state;
    logic [TAG_W-1:0]       r_out_tag;

    assign w_in_beat = '{state: bus.state_in, key: bus.round_key, fin: bus.final_round,
                         dec: bus.decrypt, tag: bus.in_tag};

    // Unrolled form of ready[i] = ~valid[i] | ready[i+1]: free of in_valid by construction.
    for (genvar i = 0; i < PIPE_STAGES; i++) begin : g_stage
        assign w_rdy[i] = bus.out_ready | ~(&r_vld[c_last:i]);
        if (i == 0) begin : g_head
            assign w_up_vld[i] = bus.in_valid;
        end else begin : g_link
            assign w_up_vld[i] = r_vld[i-1];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_vld <= '0;
        end else begin
            for (int i = 0; i < PIPE_STAGES; i++)
                if (w_rdy[i]) r_vld[i] <= w_up_vld[i];
        end
    end

    if (PIPE_STAGES < 1 || PIPE_STAGES > 3) begin : g_bad_stages
        $error("aes_round_pipe: PIPE_STAGES must be 1, 2 or 3");
    end else if (PIPE_STAGES == 1) begin : g_ps1
        assign w_out_state = stage_finish(stage_mix(stage_subshift(w_in_beat)));
        assign w_out_tag   = w_in_beat.tag;
    end else if (PIPE_STAGES == 2) begin : g_ps2
        beat_t r_s0;
        always_ff @(posedge clk) begin
            if (w_rdy[0] && w_up_vld[0]) r_s0 <= stage_subshift(w_in_beat);
        end
        assign w_out_state = stage_finish(stage_mix(r_s0));
        assign w_out_tag   = r_s0.tag;
    end else begin : g_ps3
        beat_t r_s0;
        beat_t r_s1;
        always_ff @(posedge clk) begin
            if (w_rdy[0] && w_up_vld[0]) r_s0 <= stage_subshift(w_in_beat);
            if (w_rdy[1] && w_up_vld[1]) r_s1 <= stage_mix(r_s0);
        end
        assign w_out_state = stage_finish(r_s1);
        assign w_out_tag   = r_s1.tag;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_out_state <= '0;
            r_out_tag   <= '0;
        end else if (w_rdy[c_last] && w_up_vld[c_last]) begin
            r_out_state <= w_out_state;
            r_out_tag   <= w_out_tag;
        end
    end

    assign bus.in_ready  = w_rdy[0];
    assign bus.out_valid = r_vld[c_last];
    assign bus.state_out = r_out_state;
    assign bus.out_tag   = r_out_tag;
    assign busy          = |r_vld;
endmodule
`default_nettype wire

// File: tb/tb_aes_round_pipe.sv
`default_nettype none
// ============================================================================
// Module   : tb_aes_round_pipe
// Brief    : Directed self-checking bench for aes_round_pipe (1, 2, 3 stages).
// Revision : 1.0 - initial release
// ============================================================================
module tb_aes_round_pipe;
    localparam int c_ps = 2;

    logic clk;
    logic rst;
    logic in_valid, final_round, decrypt, out_ready;
    logic [127:0] state_in, round_key;
    logic [3:0] in_tag;
    logic busy1, busy2, busy3;

    int n_checks;
    int n_pass;

    logic [127:0] b_state [32];
    logic [127:0] b_key   [32];
    logic [127:0] b_exp   [32];
    logic         b_fin   [32];
    logic         b_dec   [32];
    logic [3:0]   b_tag   [32];

    logic [2047:0] m_sbox_bits = {
        128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16};

    aes_round_pipe_if #(.TAG_W(4)) ifc1 ();
    aes_round_pipe_if #(.TAG_W(4)) ifc2 ();
    aes_round_pipe_if #(.TAG_W(4)) ifc3 ();

    assign ifc1.in_valid = in_valid;    assign ifc2.in_valid = in_valid;    assign ifc3.in_valid = in_valid;
    assign ifc1.state_in = state_in;    assign ifc2.state_in = state_in;    assign ifc3.state_in = state_in;
    assign ifc1.round_key = round_key;  assign ifc2.round_key = round_key;  assign ifc3.round_key = round_key;
    assign ifc1.final_round = final_round; assign ifc2.final_round = final_round; assign ifc3.final_round = final_round;
    assign ifc1.decrypt = decrypt;      assign ifc2.decrypt = decrypt;      assign ifc3.decrypt = decrypt;
    assign ifc1.in_tag = in_tag;        assign ifc2.in_tag = in_tag;        assign ifc3.in_tag = in_tag;
    assign ifc1.out_ready = out_ready;  assign ifc2.out_ready = out_ready;  assign ifc3.out_ready = out_ready;

    aes_round_pipe #(.PIPE_STAGES(1), .TAG_W(4)) u_dut1 (.clk(clk), .rst(rst), .bus(ifc1.slave), .busy(busy1));
    aes_round_pipe #(.PIPE_STAGES(2), .TAG_W(4)) u_dut2 (.clk(clk), .rst(rst), .bus(ifc2.slave), .busy(busy2));
    aes_round_pipe #(.PIPE_STAGES(3), .TAG_W(4)) u_dut3 (.clk(clk), .rst(rst), .bus(ifc3.slave), .busy(busy3));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h", nm, obs, exp);
    endtask

    // Reference round model: table S-box, search for the inverse, MC^3 as InvMixColumns.
    function automatic logic [7:0] m_sb(input logic [7:0] x);
        return m_sbox_bits[2047-8*int'(x) -: 8];
    endfunction

    function automatic logic [7:0] m_isb(input logic [7:0] x);
        for (int v = 0; v < 256; v++)
            if (m_sb(8'(v)) == x) return 8'(v);
        return 8'h00;
    endfunction

    function automatic logic [7:0] m_xt(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [127:0] m_sr(input logic [127:0] s);
        logic [127:0] o;
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                o[127-8*(r+4*c) -: 8] = s[127-8*(r+4*((c+r)%4)) -: 8];
        return o;
    endfunction

    function automatic logic [127:0] m_mc(input logic [127:0] s);
        logic [127:0] o;
        logic [7:0] a0, a1, a2, a3, t;
        for (int c = 0; c < 4; c++) begin
            a0 = s[127-32*c -: 8]; a1 = s[119-32*c -: 8];
            a2 = s[111-32*c -: 8]; a3 = s[103-32*c -: 8];
            t  = a0 ^ a1 ^ a2 ^ a3;
            o[127-32*c -: 8] = a0 ^ t ^ m_xt(a0 ^ a1);
            o[119-32*c -: 8] = a1 ^ t ^ m_xt(a1 ^ a2);
            o[111-32*c -: 8] = a2 ^ t ^ m_xt(a2 ^ a3);
            o[103-32*c -: 8] = a3 ^ t ^ m_xt(a3 ^ a0);
        end
        return o;
    endfunction

    function automatic logic [127:0] m_round(input logic [127:0] st, input logic [127:0] key,
                                             input logic fin, input logic dec);
        logic [127:0] t;
        if (!dec) begin
            for (int k = 0; k < 16; k++) t[127-8*k -: 8] = m_sb(st[127-8*k -: 8]);
            t = m_sr(t);
            if (!fin) t = m_mc(t);
            return t ^ key;
        end
        t = m_sr(m_sr(m_sr(st)));
        for (int k = 0; k < 16; k++) t[127-8*k -: 8] = m_isb(t[127-8*k -: 8]);
        t = t ^ key;
        if (!fin) t = m_mc(m_mc(m_mc(t)));
        return t;
    endfunction

    task automatic load_beats(input int n, input int seed);
        for (int i = 0; i < n; i++) begin
            b_state[i] = {4{32'(i * 32'h9e3779b9 + seed)}} ^ 128'h00112233445566778899aabbccddeeff;
            b_key[i]   = {4{32'(i * 32'h7f4a7c15 ^ seed)}} ^ 128'h000102030405060708090a0b0c0d0e0f;
            b_dec[i]   = i[0];
            b_fin[i]   = (i % 3 == 2);
            b_tag[i]   = 4'(i);
            b_exp[i]   = m_round(b_state[i], b_key[i], b_fin[i], b_dec[i]);
        end
    endtask

    task automatic drive_beat(input int i);
        state_in = b_state[i]; round_key = b_key[i];
        final_round = b_fin[i]; decrypt = b_dec[i]; in_tag = b_tag[i];
    endtask

    // Entered and left just after a rising edge; scoreboards the PIPE_STAGES=2 instance.
    task automatic stream(input int n, input logic [31:0] pat, input string nm,
                          output int first_out, output int last_out);
        int sent, got, occ, cyc, stray;
        logic stall_prev, in_fire, out_fire;
        logic [127:0] st_prev;
        logic [3:0] tg_prev;
        sent = 0; got = 0; occ = 0; cyc = 0; stray = 0;
        first_out = -1; last_out = -1;
        stall_prev = 1'b0; st_prev = '0; tg_prev = '0;
        while (got < n && cyc < 400) begin
            out_ready = pat[cyc % 32];
            in_valid  = (sent < n);
            if (sent < n) drive_beat(sent);
            @(negedge clk);
            if (stall_prev) begin
                check({nm, "_hold_valid"}, ifc2.out_valid, 1'b1);
                check({nm, "_hold_state"}, ifc2.state_out, st_prev);
                check({nm, "_hold_tag"}, ifc2.out_tag, tg_prev);
            end
            check({nm, "_in_ready"}, ifc2.in_ready, !(occ == c_ps && !out_ready));
            check({nm, "_busy"}, busy2, occ != 0);
            in_fire  = in_valid & ifc2.in_ready;
            out_fire = ifc2.out_valid & out_ready;
            if (out_fire) begin
                check({nm, "_tag"}, ifc2.out_tag, b_tag[got]);
                check({nm, "_state"}, ifc2.state_out, b_exp[got]);
                if (first_out < 0) first_out = cyc;
                last_out = cyc;
                got++;
            end
            stall_prev = ifc2.out_valid & ~out_ready;
            st_prev = ifc2.state_out;
            tg_prev = ifc2.out_tag;
            if (in_fire) sent++;
            occ = occ + int'(in_fire) - int'(out_fire);
            @(posedge clk); #1;
            cyc++;
        end
        check({nm, "_count"}, got, n);
        in_valid = 1'b0;
        out_ready = 1'b1;
        repeat (4) begin
            @(negedge clk);
            if (ifc2.out_valid) stray++;
        end
        check({nm, "_stray"}, stray, 0);
        @(posedge clk); #1;
    endtask

    task automatic sweep(input logic [127:0] st, input logic [127:0] key, input logic fin,
                         input logic dec, input logic [127:0] exp, input string nm);
        int lat [3];
        logic [127:0] res [3];
        logic [3:0] tg [3];
        for (int i = 0; i < 3; i++) begin lat[i] = -1; res[i] = '0; tg[i] = '0; end
        out_ready = 1'b1; in_valid = 1'b1;
        state_in = st; round_key = key; final_round = fin; decrypt = dec; in_tag = 4'h5;
        for (int k = 1; k <= 6; k++) begin
            @(posedge clk); #1;
            if (k == 1) in_valid = 1'b0;
            if (ifc1.out_valid && lat[0] < 0) begin lat[0] = k; res[0] = ifc1.state_out; tg[0] = ifc1.out_tag; end
            if (ifc2.out_valid && lat[1] < 0) begin lat[1] = k; res[1] = ifc2.state_out; tg[1] = ifc2.out_tag; end
            if (ifc3.out_valid && lat[2] < 0) begin lat[2] = k; res[2] = ifc3.state_out; tg[2] = ifc3.out_tag; end
        end
        for (int i = 0; i < 3; i++) begin
            check($sformatf("%s_ps%0d_latency", nm, i + 1), lat[i], i + 1);
            check($sformatf("%s_ps%0d_state", nm, i + 1), res[i], exp);
            check($sformatf("%s_ps%0d_tag", nm, i + 1), tg[i], 4'h5);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "simulation watchdog expired");
    end

    initial begin
        int f_out, l_out;
        n_checks = 0; n_pass = 0;
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        state_in = '0; round_key = '0; final_round = 1'b0; decrypt = 1'b0; in_tag = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_out_valid", ifc2.out_valid, 1'b0);
        check("rst_busy", busy2, 1'b0);
        check("rst_state_out", ifc2.state_out, 128'h0);
        check("rst_out_tag", ifc2.out_tag, 4'h0);
        check("rst_ps1_valid", ifc1.out_valid | busy1, 1'b0);
        check("rst_ps3_valid", ifc3.out_valid | busy3, 1'b0);
        @(negedge clk) rst = 1'b0;
        #1 check("rst_in_ready", ifc2.in_ready, 1'b1);
        @(posedge clk); #1;

        sweep(128'h00102030405060708090a0b0c0d0e0f0, 128'hd6aa74fdd2af72fadaa678f1d6ab76fe,
              1'b0, 1'b0, 128'h89d810e8855ace682d1843d8cb128fe4, "fwd");
        sweep(128'h6353e08c0960e104cd70b751bacad0e7, 128'h000102030405060708090a0b0c0d0e0f,
              1'b1, 1'b1, 128'h00112233445566778899aabbccddeeff, "invfin");

        load_beats(8, 32'h1234);
        stream(8, 32'b1011_0010_0110_1001_1100_0101_0011_1010, "bp", f_out, l_out);

        load_beats(20, 32'h0bad);
        stream(20, 32'hffff_ffff, "tp", f_out, l_out);
        check("tp_first_latency", f_out, c_ps);
        check("tp_back_to_back", l_out - f_out, 19);

        load_beats(3, 32'h0099);
        out_ready = 1'b0; in_valid = 1'b1; drive_beat(1);
        @(posedge clk); #1;
        drive_beat(2);
        @(posedge clk); #1;
        in_valid = 1'b0;
        check("full_out_valid", ifc2.out_valid, 1'b1);
        check("full_in_ready", ifc2.in_ready, 1'b0);
        #2 rst = 1'b1;
        #1;
        check("midrst_out_valid", ifc2.out_valid, 1'b0);
        check("midrst_busy", busy2, 1'b0);
        check("midrst_state_out", ifc2.state_out, 128'h0);
        @(negedge clk) rst = 1'b0;
        #1 check("midrst_in_ready", ifc2.in_ready, 1'b1);
        @(posedge clk); #1;
        stream(1, 32'hffff_ffff, "after_rst", f_out, l_out);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
`default_nettype wire
